// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared definitions for the decoder, EX stage and the MEM stage
//   (mem_access): memory operation codes, MEM-stage FSM states, lane-select
//   width and small classification helpers for operation codes.
//   Operation codes arrive as plain 4-bit values; codes 9..15 are treated
//   as "no memory operation" by the helpers below.

package mem_access_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int BYTE_SEL_WIDTH = 4;
    localparam int TIMER_WIDTH    = 8;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_t;

    typedef enum logic {
        MEM_STATE_IDLE = 1'b0,
        MEM_STATE_BUSY = 1'b1
    } mem_state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_OP_LB)  || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
               (op == MEM_OP_LHU) || (op == MEM_OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Halfwords must sit on an even address, words on a multiple of four.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
        word_op = (op == MEM_OP_LW) || (op == MEM_OP_SW);
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if
//   Variable-latency request/ready data-memory port.
//   master (MEM stage): mem_request, mem_write, mem_addr (word aligned),
//                       mem_byte_select (bit3 = data[31:24]), mem_write_data
//   slave  (memory)   : mem_ready (access completes this cycle),
//                       mem_read_data (valid while mem_ready=1)

interface mem_access_if
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);

    logic                      mem_request;
    logic                      mem_write;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [BYTE_SEL_WIDTH-1:0] mem_byte_select;
    logic [WORD_WIDTH-1:0]     mem_write_data;
    logic                      mem_ready;
    logic [WORD_WIDTH-1:0]     mem_read_data;

    modport master (
        output mem_request,
        output mem_write,
        output mem_addr,
        output mem_byte_select,
        output mem_write_data,
        input  mem_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_request,
        input  mem_write,
        input  mem_addr,
        input  mem_byte_select,
        input  mem_write_data,
        output mem_ready,
        output mem_read_data
    );

endinterface

// File: rtl/mem_access_lane_align.sv
// mem_lane_align
//   Purely combinational big-endian lane steering for MIPS loads/stores.
//   Ports:
//     op             in  4   memory operation code (mem_access_pkg encoding)
//     off            in  2   byte offset within the word (addr[1:0])
//     store_data     in  32  rt value for stores
//     read_data      in  32  word returned by memory
//     byte_select    out 4   active lanes, bit3 = data[31:24]
//     write_data_out out 32  store data replicated into every lane
//     load_value     out 32  selected byte/half right-aligned and extended
//   Halfword accesses look at off[1] only and word accesses ignore off, so a
//   misaligned address behaves as if its low offending bits were zero.

module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [3:0]                op,
    input  logic [1:0]                off,
    input  logic [WORD_WIDTH-1:0]     store_data,
    input  logic [WORD_WIDTH-1:0]     read_data,
    output logic [BYTE_SEL_WIDTH-1:0] byte_select,
    output logic [WORD_WIDTH-1:0]     write_data_out,
    output logic [WORD_WIDTH-1:0]     load_value
);

    function automatic logic [WORD_WIDTH-1:0] extend_byte(input logic [7:0] b,
                                                          input logic       sign);
        logic signed [7:0] sb;
        sb = b;
        return sign ? 32'(sb) : {24'b0, b};
    endfunction

    function automatic logic [WORD_WIDTH-1:0] extend_half(input logic [15:0] h,
                                                          input logic        sign);
        logic signed [15:0] sh;
        sh = h;
        return sign ? 32'(sh) : {16'b0, h};
    endfunction

    logic [7:0]                byte_lane;
    logic [15:0]               half_lane;
    logic [BYTE_SEL_WIDTH-1:0] byte_mask;
    logic [BYTE_SEL_WIDTH-1:0] half_mask;

    // Lane 3 holds the lowest byte address (big-endian).
    always_comb begin
        byte_lane = read_data[31:24];
        case (off)
            2'd0:    byte_lane = read_data[31:24];
            2'd1:    byte_lane = read_data[23:16];
            2'd2:    byte_lane = read_data[15:8];
            default: byte_lane = read_data[7:0];
        endcase
        half_lane = off[1] ? read_data[15:0] : read_data[31:16];
        byte_mask = 4'b1000 >> off;
        half_mask = off[1] ? 4'b0011 : 4'b1100;
    end

    always_comb begin
        byte_select    = '0;
        write_data_out = '0;
        load_value     = '0;
        case (op)
            MEM_OP_LB: begin
                byte_select = byte_mask;
                load_value  = extend_byte(byte_lane, 1'b1);
            end
            MEM_OP_LBU: begin
                byte_select = byte_mask;
                load_value  = extend_byte(byte_lane, 1'b0);
            end
            MEM_OP_LH: begin
                byte_select = half_mask;
                load_value  = extend_half(half_lane, 1'b1);
            end
            MEM_OP_LHU: begin
                byte_select = half_mask;
                load_value  = extend_half(half_lane, 1'b0);
            end
            MEM_OP_LW: begin
                byte_select = 4'b1111;
                load_value  = read_data;
            end
            MEM_OP_SB: begin
                byte_select    = byte_mask;
                write_data_out = {4{store_data[7:0]}};
            end
            MEM_OP_SH: begin
                byte_select    = half_mask;
                write_data_out = {2{store_data[15:0]}};
            end
            MEM_OP_SW: begin
                byte_select    = 4'b1111;
                write_data_out = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access
//   Registered MEM pipeline stage. Passes the EX writeback triple through
//   with one cycle of latency and performs MIPS loads/stores over a
//   variable-latency request/ready memory port, stalling IF..EX while an
//   access is outstanding and aborting with a bus error after
//   TIMEOUT_CYCLES busy cycles without mem_ready.
//   Ports:
//     clock, reset                 pipeline clock, synchronous active-high reset
//     input_write_enable/addr/data writeback triple from EX
//     input_mem_op/mem_addr        memory operation and effective byte address
//     input_store_data             rt value for stores
//     stall_request                combinational hold request for IF..EX
//     mem (mem_access_if.master)   data-memory port
//     write_enable/addr/data       registered writeback triple
//     bus_error                    one-cycle pulse after an access timeout
//     align_error                  one-cycle pulse on a misaligned access
//                                  (present only with MEM_ALIGN_CHECK_EN)
//   Build option: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
//   accesses; otherwise the offending low address bits are treated as zero.

module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      input_write_enable,
    input  logic [REG_ADDR_WIDTH-1:0] input_write_addr,
    input  logic [WORD_WIDTH-1:0]     input_write_data,
    input  logic [3:0]                input_mem_op,
    input  logic [ADDR_WIDTH-1:0]     input_mem_addr,
    input  logic [WORD_WIDTH-1:0]     input_store_data,
    output logic                      stall_request,
    mem_access_if.master              mem,
    output logic                      write_enable,
    output logic [REG_ADDR_WIDTH-1:0] write_addr,
    output logic [WORD_WIDTH-1:0]     write_data,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                      align_error,
`endif
    output logic                      bus_error
);

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    mem_state_t                state;
    mem_state_t                state_next;
    logic [TIMER_WIDTH-1:0]    timer;

    logic [3:0]                hold_op_p1;
    logic [ADDR_WIDTH-1:0]     hold_addr_p1;
    logic [WORD_WIDTH-1:0]     hold_store_p1;
    logic [REG_ADDR_WIDTH-1:0] hold_waddr_p1;
    logic                      hold_we_p1;

    logic                      busy;
    logic                      start_misaligned;
    logic                      start_access;
    logic                      timeout_hit;

    logic [BYTE_SEL_WIDTH-1:0] lane_bsel;
    logic [WORD_WIDTH-1:0]     lane_wdata;
    logic [WORD_WIDTH-1:0]     lane_load;

`ifdef MEM_ALIGN_CHECK_EN
    assign start_misaligned = is_misaligned(input_mem_op, input_mem_addr[1:0]);
`else
    assign start_misaligned = 1'b0;
`endif

    assign busy         = (state == MEM_STATE_BUSY);
    assign start_access = is_mem_op(input_mem_op) && !start_misaligned;
    // A late ready in the last allowed cycle still completes the access.
    assign timeout_hit  = busy && !mem.mem_ready && (timer == TIMER_LAST);

    mem_lane_align u_lane_align (
        .op             (hold_op_p1),
        .off            (hold_addr_p1[1:0]),
        .store_data     (hold_store_p1),
        .read_data      (mem.mem_read_data),
        .byte_select    (lane_bsel),
        .write_data_out (lane_wdata),
        .load_value     (lane_load)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= MEM_STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MEM_STATE_IDLE: if (start_access) state_next = MEM_STATE_BUSY;
            MEM_STATE_BUSY: if (mem.mem_ready || timeout_hit) state_next = MEM_STATE_IDLE;
            default:        state_next = MEM_STATE_IDLE;
        endcase
    end

    always_comb begin
        stall_request       = 1'b0;
        mem.mem_request     = 1'b0;
        mem.mem_write       = 1'b0;
        mem.mem_addr        = '0;
        mem.mem_byte_select = '0;
        mem.mem_write_data  = '0;
        case (state)
            MEM_STATE_IDLE: begin
                stall_request = start_access;
            end
            MEM_STATE_BUSY: begin
                // Releasing the stall in the timeout cycle lets EX move on
                // past the aborted instruction.
                stall_request       = !mem.mem_ready && !timeout_hit;
                mem.mem_request     = 1'b1;
                mem.mem_write       = is_store(hold_op_p1);
                mem.mem_addr        = {hold_addr_p1[ADDR_WIDTH-1:2], 2'b00};
                mem.mem_byte_select = lane_bsel;
                mem.mem_write_data  = is_store(hold_op_p1) ? lane_wdata : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer <= '0;
        end else if (busy && !mem.mem_ready && !timeout_hit) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    // ---- stage p1: access holding registers (EX is frozen while busy) ----
    always_ff @(posedge clock) begin
        if (!busy && start_access) begin
            hold_op_p1    <= input_mem_op;
            hold_addr_p1  <= input_mem_addr;
            hold_store_p1 <= input_store_data;
            hold_waddr_p1 <= input_write_addr;
            hold_we_p1    <= input_write_enable;
        end
    end

    // ---- stage p2: registered writeback triple and error pulses ----
    always_ff @(posedge clock) begin
        if (reset) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            bus_error    <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            if (!busy) begin
                if (!is_mem_op(input_mem_op)) begin
                    write_enable <= input_write_enable;
                    write_addr   <= input_write_addr;
                    write_data   <= input_write_data;
                end else begin
                    write_enable <= 1'b0;
                end
            end else if (mem.mem_ready) begin
                if (is_load(hold_op_p1)) begin
                    write_enable <= hold_we_p1;
                    write_addr   <= hold_waddr_p1;
                    write_data   <= lane_load;
                end else begin
                    write_enable <= 1'b0;
                end
            end else begin
                write_enable <= 1'b0;
                bus_error    <= timeout_hit;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            align_error <= 1'b0;
        end else begin
            align_error <= !busy && start_misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
//   Directed self-checking bench for mem_access (TIMEOUT_CYCLES=4).
//   Covers reset, ALU passthrough, byte/half/word loads and stores, zero-wait
//   completion, timeout, reset during an access and the MEM_ALIGN_CHECK_EN
//   build option.

module tb_mem_access;
    import mem_access_pkg::*;

    localparam int AW = 32;
    localparam int RW = 5;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_we;
    logic [RW-1:0] in_waddr;
    logic [31:0]   in_wdata;
    logic [3:0]    in_op;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_store;
    logic          stall_request;
    logic          write_enable;
    logic [RW-1:0] write_addr;
    logic [31:0]   write_data;
    logic          bus_error;
`ifdef MEM_ALIGN_CHECK_EN
    logic          align_error;
`endif

    always #5 clock = ~clock;

    mem_access_if #(.ADDR_WIDTH(AW)) mif ();

    mem_access #(
        .ADDR_WIDTH     (AW),
        .REG_ADDR_WIDTH (RW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .input_write_enable (in_we),
        .input_write_addr   (in_waddr),
        .input_write_data   (in_wdata),
        .input_mem_op       (in_op),
        .input_mem_addr     (in_addr),
        .input_store_data   (in_store),
        .stall_request      (stall_request),
        .mem                (mif),
        .write_enable       (write_enable),
        .write_addr         (write_addr),
        .write_data         (write_data),
`ifdef MEM_ALIGN_CHECK_EN
        .align_error        (align_error),
`endif
        .bus_error          (bus_error)
    );

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int req_cnt = 0;
    int berr_cnt = 0;

    always @(negedge clock) begin
        if (stall_request) stall_cnt <= stall_cnt + 1;
        if (mif.mem_request) req_cnt <= req_cnt + 1;
        if (bus_error) berr_cnt <= berr_cnt + 1;
    end

    logic        snap_req;
    logic        snap_write;
    logic [31:0] snap_addr;
    logic [3:0]  snap_bsel;
    logic [31:0] snap_wdata;
    logic        snap_we;
    int          s0;
    int          r0;
    int          b0;
    logic        seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_op    = MEM_OP_NONE;
        in_we    = 1'b0;
        in_waddr = '0;
        in_wdata = '0;
        in_addr  = '0;
        in_store = '0;
    endtask

    // Presents one memory op, snapshots the bus in the first BUSY cycle,
    // answers after `waits` not-ready BUSY cycles, then idles EX.
    task automatic mem_op_run(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sd, input logic [RW-1:0] wa,
                              input int waits, input logic [31:0] rdata);
        in_op    = op;
        in_addr  = addr;
        in_store = sd;
        in_waddr = wa;
        in_we    = 1'b1;
        in_wdata = 32'h0BAD0BAD;
        s0 = stall_cnt;
        r0 = req_cnt;
        tick();
        snap_req   = mif.mem_request;
        snap_write = mif.mem_write;
        snap_addr  = mif.mem_addr;
        snap_bsel  = mif.mem_byte_select;
        snap_wdata = mif.mem_write_data;
        snap_we    = write_enable;
        for (int i = 0; i < waits; i++) tick();
        mif.mem_ready     = 1'b1;
        mif.mem_read_data = rdata;
        tick();
        idle_inputs();
        mif.mem_ready     = 1'b0;
        mif.mem_read_data = '0;
    endtask

    initial begin
        // Reset with a live ALU triple on the inputs: outputs must stay 0.
        reset = 1'b1;
        idle_inputs();
        in_we = 1'b1; in_waddr = 5'd8; in_wdata = 32'hFFFF_FFFF;
        mif.mem_ready = 1'b0;
        mif.mem_read_data = '0;
        tick();
        tick();
        chk("reset_we", write_enable, 0);
        chk("reset_waddr", write_addr, 0);
        chk("reset_wdata", write_data, 0);
        chk("reset_req", mif.mem_request, 0);
        chk("reset_berr", bus_error, 0);

        // ALU passthrough.
        reset = 1'b0;
        in_op = MEM_OP_NONE; in_we = 1'b1; in_waddr = 5'd8; in_wdata = 32'hDEADBEEF;
        s0 = stall_cnt;
        #1;
        chk("alu_stall", stall_request, 0);
        tick();
        chk("alu_we", write_enable, 1);
        chk("alu_waddr", write_addr, 8);
        chk("alu_wdata", write_data, 32'hDEADBEEF);
        idle_inputs();
        chk("alu_stall_cnt", stall_cnt - s0, 0);

        // LB with three wait cycles.
        mem_op_run(MEM_OP_LB, 32'h0000_1001, 32'h0, 5'd3, 3, 32'h11A2_3344);
        chk("lb_req", snap_req, 1);
        chk("lb_write", snap_write, 0);
        chk("lb_addr", snap_addr, 32'h0000_1000);
        chk("lb_bsel", snap_bsel, 4'b0100);
        chk("lb_bubble", snap_we, 0);
        chk("lb_stall_cnt", stall_cnt - s0, 4);
        chk("lb_req_cnt", req_cnt - r0, 4);
        chk("lb_we", write_enable, 1);
        chk("lb_waddr", write_addr, 3);
        chk("lb_wdata", write_data, 32'hFFFF_FFA2);

        mem_op_run(MEM_OP_LBU, 32'h0000_1001, 32'h0, 5'd4, 3, 32'h11A2_3344);
        chk("lbu_wdata", write_data, 32'h0000_00A2);
        chk("lbu_waddr", write_addr, 4);

        // SH at offset 2, zero-wait ready.
        mem_op_run(MEM_OP_SH, 32'h0000_1002, 32'h0000_BEEF, 5'd9, 0, 32'h0);
        chk("sh_write", snap_write, 1);
        chk("sh_addr", snap_addr, 32'h0000_1000);
        chk("sh_bsel", snap_bsel, 4'b0011);
        chk("sh_wdata", snap_wdata, 32'hBEEF_BEEF);
        chk("sh_stall_cnt", stall_cnt - s0, 1);
        chk("sh_req_cnt", req_cnt - r0, 1);
        chk("sh_we", write_enable, 0);

        // Halfword loads, both offsets.
        mem_op_run(MEM_OP_LH, 32'h0000_2000, 32'h0, 5'd10, 1, 32'h8001_7FFF);
        chk("lh_bsel", snap_bsel, 4'b1100);
        chk("lh_wdata", write_data, 32'hFFFF_8001);
        chk("lh_waddr", write_addr, 10);
        mem_op_run(MEM_OP_LHU, 32'h0000_2002, 32'h0, 5'd11, 0, 32'h1234_8765);
        chk("lhu_bsel", snap_bsel, 4'b0011);
        chk("lhu_wdata", write_data, 32'h0000_8765);

        // SB at offset 3.
        mem_op_run(MEM_OP_SB, 32'h0000_3003, 32'hABCD_EF5A, 5'd1, 2, 32'h0);
        chk("sb_bsel", snap_bsel, 4'b0001);
        chk("sb_wdata", snap_wdata, 32'h5A5A_5A5A);
        chk("sb_we", write_enable, 0);

        // Timeout: LW that never gets mem_ready.
        in_op = MEM_OP_LW; in_addr = 32'h0000_4000; in_we = 1'b1; in_waddr = 5'd11;
        s0 = stall_cnt; r0 = req_cnt; b0 = berr_cnt;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus_error) seen = 1'b1;
        end
        idle_inputs();
        chk("to_pulse", seen, 1);
        chk("to_req_cnt", req_cnt - r0, 4);
        chk("to_stall_cnt", stall_cnt - s0, 4);
        chk("to_we", write_enable, 0);
        chk("to_req_idle", mif.mem_request, 0);
        tick();
        chk("to_pulse_end", bus_error, 0);
        chk("to_berr_cnt", berr_cnt - b0, 1);

        // ALU op after timeout.
        in_op = MEM_OP_NONE; in_we = 1'b1; in_waddr = 5'd12; in_wdata = 32'hCAFE_F00D;
        tick();
        idle_inputs();
        chk("post_to_we", write_enable, 1);
        chk("post_to_waddr", write_addr, 12);
        chk("post_to_wdata", write_data, 32'hCAFE_F00D);

        // Reset during the second BUSY cycle; a late ready is ignored.
        in_op = MEM_OP_LW; in_addr = 32'h0000_5004; in_we = 1'b1; in_waddr = 5'd7;
        tick();
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
        mif.mem_ready = 1'b1;
        mif.mem_read_data = 32'h5555_5555;
        #1;
        chk("rst_busy_req", mif.mem_request, 0);
        chk("rst_busy_stall", stall_request, 0);
        tick();
        chk("rst_busy_we", write_enable, 0);
        chk("rst_busy_waddr", write_addr, 0);
        chk("rst_busy_wdata", write_data, 0);
        chk("rst_busy_berr", bus_error, 0);
        mif.mem_ready = 1'b0;
        mif.mem_read_data = '0;

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned LW is rejected without touching memory.
        in_op = MEM_OP_LW; in_addr = 32'h0000_1002; in_we = 1'b1; in_waddr = 5'd13;
        r0 = req_cnt;
        #1;
        chk("al_stall", stall_request, 0);
        chk("al_req", mif.mem_request, 0);
        tick();
        idle_inputs();
        chk("al_pulse", align_error, 1);
        chk("al_we", write_enable, 0);
        tick();
        chk("al_pulse_end", align_error, 0);
        chk("al_req_cnt", req_cnt - r0, 0);
`else
        // Misaligned LW runs as an aligned word access.
        mem_op_run(MEM_OP_LW, 32'h0000_1002, 32'h0, 5'd13, 1, 32'h89AB_CDEF);
        chk("mis_addr", snap_addr, 32'h0000_1000);
        chk("mis_bsel", snap_bsel, 4'b1111);
        chk("mis_we", write_enable, 1);
        chk("mis_waddr", write_addr, 13);
        chk("mis_wdata", write_data, 32'h89AB_CDEF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Parametrised successor to the combinational MEM stage.
- Registers the EX→WB writeback triple and performs MIPS loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) over a variable-latency request/ready data-memory port.
- Stalls the upstream pipeline while an access is outstanding.
- Aborts with a bus error after a configurable timeout.

Parameters:
- ADDR_WIDTH, 32, data-memory byte address width.
- REG_ADDR_WIDTH, 5, register-file address width.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles waiting for mem_ready (legal 1..255).

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  synchronous, active-high (`ENABLE).
- input_write_enable  in  1  writeback enable from EX.
- input_write_addr  in  REG_ADDR_WIDTH  destination register.
- input_write_data  in  32  ALU result; used as writeback data for non-memory ops.
- input_mem_op  in  4  memory operation code (package encoding).
- input_mem_addr  in  ADDR_WIDTH  effective byte address.
- input_store_data  in  32  rt value for stores.
- stall_request  out  1  combinational request to hold IF..EX.
- mem_request  out  1  data-memory request valid.
- mem_write  out  1  1=store, 0=load.
- mem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits forced 0).
- mem_byte_select  out  4  byte lanes; bit3 = data[31:24].
- mem_write_data  out  32  store data replicated into the selected lanes.
- mem_ready  in  1  memory completes the access this cycle.
- mem_read_data  in  32  load data, valid when mem_ready=1.
- write_enable  out  1  registered writeback enable.
- write_addr  out  REG_ADDR_WIDTH  registered writeback address.
- write_data  out  32  registered writeback data.
- bus_error  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset:
  - state=IDLE and timeout counter=0.
  - write_enable=`DISABLE; write_addr=0; write_data=0.
  - mem_request=0 and bus_error=0.
  - Reset mid-access drops the access; a late mem_ready in IDLE is ignored.
- IDLE with mem_op=NONE:
  - Outputs register the input triple at the next edge (1-cycle latency).
  - stall_request=0.
- IDLE with a load/store op:
  - stall_request=1.
  - At the edge: capture op, address, store data, write_addr and write_enable into holding registers; go to BUSY.
  - write_enable registers 0 (bubble).
- BUSY:
  - Drive mem_request=1 with the held address, lanes and data. Outputs hold until mem_ready.
  - stall_request = !mem_ready.
  - Counter increments each cycle that mem_ready=0.
  - EX inputs are ignored (EX is held by the stall).
- BUSY with mem_ready=1:
  - At the edge: go to IDLE and clear the counter. Upstream advances on the same edge.
  - Load: write_enable=held enable; write_addr=held address; write_data=extracted value.
  - Store: write_enable=0.
  - Minimum memory-op latency is 2 cycles; zero-wait ready in the first BUSY cycle is legal.
- BUSY with counter==TIMEOUT_CYCLES-1 and mem_ready=0:
  - Next cycle: bus_error=1 for one cycle, write_enable=0, state=IDLE, mem_request=0.
  - stall_request is 0 in that final BUSY cycle.
- Lanes are big-endian; off = addr[1:0].
  - Byte accesses: lane 3-off.
  - Half accesses: off 0 → lanes 3,2; off 2 → lanes 1,0.
  - Word accesses: all lanes.
- Loads: extract the selected byte/half and right-align it. LB/LH sign-extend; LBU/LHU zero-extend.
- Stores: SB replicates the byte 4×; SH replicates the half 2×; SW passes the word through.
- Misaligned addresses (half with addr[0]=1, word with addr[1:0]≠0): handling depends on MEM_ALIGN_CHECK_EN.

Optional Feature:
- MEM_ALIGN_CHECK_EN
- Defined:
  - A misaligned access in IDLE issues no memory request and causes no stall.
  - Next cycle: write_enable=0 and the extra output align_error=1 for one cycle.
- Undefined:
  - align_error port absent.
  - Low offending bits are treated as 0: half uses addr[1] only; word ignores addr[1:0].

Decomposition:
- Shared package, used by the decoder, EX and this block:
  - MEM_OP_* codes: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8.
  - FSM state constants MEM_STATE_IDLE/BUSY.
  - Byte-select width constant.
- Sub-module mem_lane_align: purely combinational. Maps (op, off, store_data, read_data) to (byte_select, write_data_out, load_value). Unit-testable in isolation.

Test Plan:
- ALU passthrough: op=NONE, we=1, addr=5'd8, data=32'hDEADBEEF → next cycle write_enable=1, write_addr=8, write_data=DEADBEEF; stall_request never 1.
- LB sign-extend: addr=32'h1001, mem_ready after 3 BUSY cycles, read_data=32'h11_A2_33_44 → byte_select=4'b0100; stall 4 cycles; write_data=FFFFFFA2. Repeat with LBU → 000000A2.
- SH at offset 2, data=32'h0000BEEF, ready in first BUSY cycle → mem_write=1, byte_select=4'b0011, mem_write_data=BEEFBEEF, write_enable=0, total latency 2 cycles.
- Timeout with TIMEOUT_CYCLES=4: LW with mem_ready held 0 → mem_request high exactly 4 cycles; bus_error pulses once; state returns to IDLE; following ALU op completes normally.
- Reset mid-BUSY: assert reset during the 2nd BUSY cycle, then mem_ready=1 → all outputs 0 and mem_request=0; the late ready produces no writeback.
- MEM_ALIGN_CHECK_EN: LW at addr=32'h1002 → no mem_request, align_error pulse, write_enable=0. With the macro undefined → mem_addr=32'h1000, normal LW.
